mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory responder for the MIPS 5-stage pipeline; the other end of the MEM-stage `mem_ren`/`mem_wen` request that the pipeline controller issues.
- Holds a word-addressed data RAM with a parameterised access latency.
- Returns load data and raises `mem_stall` so the controller freezes IF..MEM until the access completes.
- Sits between the MEM-stage pipeline register and WB data mux; `mem_stall` is ORed into the controller's stall logic.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- ADDR_BITS, 10, log2(DEPTH).
- LATENCY, 2, cycles `mem_stall` stays high per accepted access; legal range 1..15.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_ren  in  1  load request (from MEM-stage register)
- mem_wen  in  1  store request
- mem_addr  in  32  byte address (ALU result)
- mem_wdata  in  32  store data (after `fwd_m` mux)
- mem_wstrb  in  4  byte enables for store; 4'b1111 for SW
- mem_rdata  out  32  load data, valid in DONE cycle
- mem_stall  out  1  hold pipeline; access in progress
- mem_done  out  1  one-cycle pulse, access finished
- mem_err  out  1  misaligned / out-of-range / ren&wen conflict, one-cycle pulse
- dbg_addr  in  ADDR_BITS  debug word index
- dbg_data  out  32  combinational RAM read at `dbg_addr`

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cnt=0, `mem_rdata`=0, `mem_done`=0, `mem_err`=0, latched op/addr/data=0. RAM contents are not reset. `mem_stall`=0 while in reset.
- Request = `mem_valid` & (`mem_ren` | `mem_wen`).
- Legal request: addr[1:0]==0, addr[31:ADDR_BITS+2]==0, not (ren & wen).
- Word index = addr[ADDR_BITS+1:2].
- IDLE:
  - Legal request: `mem_stall`=1 combinationally in the same cycle. Latch op, index, wdata, wstrb. cnt<=LATENCY-1.
  - Next state is BUSY, or DONE directly if LATENCY==1.
  - Illegal request: no access, no stall. `mem_err`=1 registered on the next edge for one cycle; stay IDLE.
  - No request: `mem_stall`=0.
- BUSY:
  - `mem_stall`=1; inputs ignored (latched copies used); cnt decrements each cycle.
  - When cnt==1 (or on the accept edge when LATENCY==1), at the clock edge ending the last stalled cycle:
    - store: write RAM bytes selected by wstrb;
    - load: `mem_rdata` <= RAM[index];
    - state<=DONE; `mem_done`<=1.
- DONE:
  - `mem_stall`=0, `mem_done`=1 for exactly one cycle; `mem_rdata` valid.
  - Controller advances MEM->WB at this cycle's edge; state<=IDLE unconditionally.
  - A request seen in DONE is not accepted; it belongs to the instruction that is leaving.
- Total stall per legal access = exactly LATENCY cycles; the instruction occupies MEM for LATENCY+1 cycles.
- `mem_rdata` holds its value until the next load completes; stores do not modify it.
- Store followed by load to the same word: the load sees the new data, since the write commits before DONE.
- Partial wstrb: unselected bytes are unchanged.
- wstrb=0 on a store is legal; no bytes change but the full latency still applies.
- Reset mid-BUSY: access aborted, no RAM write; a store already committed at an earlier edge remains.
- `dbg_data` is an asynchronous read and is unaffected by the FSM.

Decomposition:
- Shared package / define header:
  - state encoding MR_IDLE=2'd0, MR_BUSY=2'd1, MR_DONE=2'd2;
  - error-cause constants;
  - LATENCY bounds.
- Sub-module `dmem_array`: DEPTH×32 RAM with a byte-enabled synchronous write port, a synchronous read port, and an asynchronous debug read port.
- FSM/counter stays in `mem_responder`.

Test Plan:
- LATENCY=2, SW addr 0x10 data 0xDEADBEEF, wstrb 4'hF -> `mem_stall` high 2 cycles from request cycle; `mem_done` in 3rd cycle; `dbg_addr`=4 shows 0xDEADBEEF.
- LW addr 0x10 right after the store -> `mem_rdata`=0xDEADBEEF in DONE cycle; stall exactly 2 cycles.
- SW addr 0x20 data 0x11223344 wstrb 4'b0010 over prior 0xFFFFFFFF -> word reads 0xFFFF33FF.
- LW addr 0x13 (misaligned), then addr 0x1000 (out of range with DEPTH=1024), then ren=wen=1 -> each gives a `mem_err` pulse next cycle, no stall, RAM unchanged.
- LATENCY=1 back-to-back LW 0x0, LW 0x4 -> stall 1 cycle each; DONE between them; two `mem_done` pulses 2 cycles apart.
- Assert rst_n low during BUSY of SW 0x8 (LATENCY=4) -> outputs zero immediately; word 2 unchanged; first request after release is accepted normally.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_responder_pkg;

  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int CNT_W   = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_BUSY = 2'd1,
    MR_DONE = 2'd2
  } mr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_CONFLICT = 2'd3
  } mr_err_e;

  // Conflict wins over alignment, alignment over range.
  function automatic mr_err_e classify_req(input logic [DATA_W-1:0] addr,
                                           input logic              ren,
                                           input logic              wen,
                                           input int                addr_bits);
    mr_err_e cause;
    if (ren && wen) begin
      cause = ERR_CONFLICT;
    end else if (addr[1:0] != 2'b00) begin
      cause = ERR_MISALIGN;
    end else if ((addr >> (addr_bits + 2)) != 32'd0) begin
      cause = ERR_RANGE;
    end else begin
      cause = ERR_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the MEM-stage pipeline register and the data-memory responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              mem_valid;
  logic              mem_ren;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;
  logic              mem_done;
  logic              mem_err;

  modport master (
    output mem_valid, mem_ren, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_stall, mem_done, mem_err
  );

  modport slave (
    input  mem_valid, mem_ren, mem_wen, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_stall, mem_done, mem_err
  );

endinterface

// File: rtl/mem_responder_dmem_array.sv
// Word-addressed data RAM: byte-enabled synchronous write, registered read, asynchronous debug read.
module dmem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 we_i,
  input  logic [STRB_W-1:0]    wstrb_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 re_i,
  output logic [DATA_W-1:0]    rdata_o,
  input  logic [ADDR_BITS-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]    dbg_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Load data register holds its value until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o    = rdata_q;
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder for the 5-stage pipeline: accepts a MEM-stage load/store,
// stalls the pipeline for LATENCY cycles, then pulses done with the load data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_responder_if.slave       mem,
  input  logic [ADDR_BITS-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]    dbg_data_o
);

  localparam int LAT_EFF = (LATENCY < LAT_MIN) ? LAT_MIN :
                           (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  mr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_store_q, op_store_d;
  logic [ADDR_BITS-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  req_s;
  mr_err_e               cause_s;
  logic                  stall_s;
  logic                  ram_we_s;
  logic                  ram_re_s;
  logic [ADDR_BITS-1:0]  ram_idx_s;
  logic [DATA_W-1:0]     ram_wdata_s;
  logic [STRB_W-1:0]     ram_wstrb_s;

  assign req_s   = mem.mem_valid & (mem.mem_ren | mem.mem_wen);
  assign cause_s = classify_req(mem.mem_addr, mem.mem_ren, mem.mem_wen, ADDR_BITS);

  // State, counter and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MR_IDLE;
      cnt_q      <= 4'd0;
      op_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_store_q <= op_store_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state, stall and RAM-port control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_store_d  = op_store_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    stall_s     = 1'b0;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_idx_s   = idx_q;
    ram_wdata_s = wdata_q;
    ram_wstrb_s = wstrb_q;

    case (state_q)
      MR_IDLE: begin
        if (req_s && (cause_s == ERR_NONE)) begin
          stall_s    = 1'b1;
          op_store_d = mem.mem_wen;
          idx_d      = mem.mem_addr[ADDR_BITS+1:2];
          wdata_d    = mem.mem_wdata;
          wstrb_d    = mem.mem_wstrb;
          cnt_d      = CNT_W'(LAT_EFF - 1);
          // Single-cycle latency commits straight from the live request.
          if (LAT_EFF == 1) begin
            state_d     = MR_DONE;
            done_d      = 1'b1;
            ram_we_s    = mem.mem_wen;
            ram_re_s    = mem.mem_ren;
            ram_idx_s   = mem.mem_addr[ADDR_BITS+1:2];
            ram_wdata_s = mem.mem_wdata;
            ram_wstrb_s = mem.mem_wstrb;
          end else begin
            state_d = MR_BUSY;
          end
        end else if (req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      MR_BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ram_we_s = op_store_q;
          ram_re_s = ~op_store_q;
          state_d  = MR_DONE;
          done_d   = 1'b1;
        end else begin
          state_d = MR_BUSY;
        end
      end
      MR_DONE: begin
        state_d = MR_IDLE;
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase
  end

  dmem_array #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (ram_idx_s),
    .we_i       (ram_we_s),
    .wstrb_i    (ram_wstrb_s),
    .wdata_i    (ram_wdata_s),
    .re_i       (ram_re_s),
    .rdata_o    (mem.mem_rdata),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // Stall is combinational so the controller freezes in the request cycle; forced low in reset.
  assign mem.mem_stall = rst_n & stall_s;
  assign mem.mem_done  = done_q;
  assign mem.mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 2, 1 and 4 sharing one stimulus bus.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst4_n;
  logic        drv_valid;
  logic        drv_ren;
  logic        drv_wen;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;
  logic [3:0]  drv_wstrb;
  logic [9:0]  dbg_addr;
  int          sel;

  logic [31:0] dbg1, dbg2, dbg4;
  logic        stall_s, done_s, err_s;
  logic [31:0] rdata_s, dbg_s;

  int n_checks = 0;
  int n_errors = 0;

  logic        tab_valid [5];
  logic [31:0] tab_addr  [5];
  logic        tab_stall [5];
  logic        tab_done  [5];
  logic [31:0] tab_rdata [5];

  always #5 clk = ~clk;

  mem_responder_if if1 ();
  mem_responder_if if2 ();
  mem_responder_if if4 ();

  assign if1.mem_valid = drv_valid && (sel == 1);
  assign if2.mem_valid = drv_valid && (sel == 2);
  assign if4.mem_valid = drv_valid && (sel == 4);
  assign if1.mem_ren = drv_ren;   assign if2.mem_ren = drv_ren;   assign if4.mem_ren = drv_ren;
  assign if1.mem_wen = drv_wen;   assign if2.mem_wen = drv_wen;   assign if4.mem_wen = drv_wen;
  assign if1.mem_addr = drv_addr; assign if2.mem_addr = drv_addr; assign if4.mem_addr = drv_addr;
  assign if1.mem_wdata = drv_wdata; assign if2.mem_wdata = drv_wdata; assign if4.mem_wdata = drv_wdata;
  assign if1.mem_wstrb = drv_wstrb; assign if2.mem_wstrb = drv_wstrb; assign if4.mem_wstrb = drv_wstrb;

  mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem(if1.slave), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg1));
  mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .mem(if2.slave), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg2));
  mem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .mem(if4.slave), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg4));

  // Route the selected DUT's outputs to the common observation signals.
  always_comb begin
    stall_s = 1'b0; done_s = 1'b0; err_s = 1'b0; rdata_s = 32'd0; dbg_s = 32'd0;
    case (sel)
      1: begin stall_s = if1.mem_stall; done_s = if1.mem_done; err_s = if1.mem_err; rdata_s = if1.mem_rdata; dbg_s = dbg1; end
      2: begin stall_s = if2.mem_stall; done_s = if2.mem_done; err_s = if2.mem_err; rdata_s = if2.mem_rdata; dbg_s = dbg2; end
      4: begin stall_s = if4.mem_stall; done_s = if4.mem_done; err_s = if4.mem_err; rdata_s = if4.mem_rdata; dbg_s = dbg4; end
      default: begin stall_s = 1'b0; end
    endcase
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    drv_valid = 1'b0; drv_ren = 1'b0; drv_wen = 1'b0;
    drv_addr = 32'd0; drv_wdata = 32'd0; drv_wstrb = 4'd0;
  endtask

  task automatic drive_req(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    drv_valid = 1'b1; drv_ren = ren; drv_wen = wen;
    drv_addr = addr; drv_wdata = wdata; drv_wstrb = strb;
  endtask

  // One legal access: count stalled cycles, locate the done cycle, capture load data.
  task automatic do_access(input string tag, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                           input int exp_lat, input logic chk_rd, input logic [31:0] exp_rd);
    int stalls;
    int done_at;
    logic [31:0] rd;
    stalls = 0; done_at = -1; rd = 32'd0;
    drive_req(ren, wen, addr, wdata, strb);
    for (int k = 0; k < 20 && done_at < 0; k++) begin
      @(negedge clk);
      if (stall_s) stalls++;
      if (done_s) begin done_at = k; rd = rdata_s; end
      @(posedge clk); #1;
      idle_bus();
    end
    chk_eq({tag, " stall_cycles"}, stalls, exp_lat);
    chk_eq({tag, " done_cycle"}, done_at, exp_lat);
    if (chk_rd) chk_eq({tag, " rdata"}, rd, exp_rd);
    @(negedge clk);
    chk_eq({tag, " done_pulse_end"}, {31'd0, done_s}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_illegal(input string tag, input logic ren, input logic wen, input logic [31:0] addr);
    drive_req(ren, wen, addr, 32'd0, 4'hF);
    @(negedge clk);
    chk_eq({tag, " no_stall"}, {31'd0, stall_s}, 32'd0);
    chk_eq({tag, " err_not_yet"}, {31'd0, err_s}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk_eq({tag, " err_pulse"}, {31'd0, err_s}, 32'd1);
    chk_eq({tag, " no_stall_after"}, {31'd0, stall_s}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_eq({tag, " err_cleared"}, {31'd0, err_s}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    sel = 2; dbg_addr = 10'd0;
    rst_n = 1'b0; rst4_n = 1'b0;
    drive_req(1'b0, 1'b1, 32'h10, 32'h0BAD0BAD, 4'hF);
    repeat (3) @(negedge clk);
    chk_eq("rst stall_with_req", {31'd0, if2.mem_stall}, 32'd0);
    chk_eq("rst done", {31'd0, if2.mem_done}, 32'd0);
    chk_eq("rst err", {31'd0, if2.mem_err}, 32'd0);
    chk_eq("rst rdata2", if2.mem_rdata, 32'd0);
    chk_eq("rst rdata1", if1.mem_rdata, 32'd0);
    chk_eq("rst rdata4", if4.mem_rdata, 32'd0);
    idle_bus();
    @(posedge clk); #1;
    rst_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY = 2
    do_access("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'd0);
    dbg_addr = 10'd4; #1;
    chk_eq("dbg word4", dbg_s, 32'hDEADBEEF);
    chk_eq("rdata after store", rdata_s, 32'd0);
    do_access("lw10", 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 2, 1'b1, 32'hDEADBEEF);
    do_access("sw20 full", 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 2, 1'b0, 32'd0);
    do_access("sw20 byte1", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0010, 2, 1'b0, 32'd0);
    dbg_addr = 10'd8; #1;
    chk_eq("dbg word8 partial", dbg_s, 32'hFFFF33FF);
    chk_eq("rdata held", rdata_s, 32'hDEADBEEF);
    do_access("lw20", 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 2, 1'b1, 32'hFFFF33FF);
    do_access("sw10 nostrb", 1'b0, 1'b1, 32'h10, 32'h00000000, 4'h0, 2, 1'b0, 32'd0);
    do_illegal("lw13", 1'b1, 1'b0, 32'h13);
    do_illegal("lw1000", 1'b1, 1'b0, 32'h1000);
    do_illegal("sw1010", 1'b0, 1'b1, 32'h1010);
    do_illegal("sw12", 1'b0, 1'b1, 32'h12);
    do_illegal("conflict", 1'b1, 1'b1, 32'h10);
    dbg_addr = 10'd4; #1;
    chk_eq("dbg word4 untouched", dbg_s, 32'hDEADBEEF);
    chk_eq("rdata after errors", rdata_s, 32'hFFFF33FF);

    // LATENCY = 1: back-to-back loads, each held through its DONE cycle
    sel = 1; #1;
    do_access("l1 sw0", 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1, 1'b0, 32'd0);
    do_access("l1 sw4", 1'b0, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, 1, 1'b0, 32'd0);
    tab_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tab_addr  = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h0};
    tab_stall = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tab_done  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab_rdata = '{32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A};
    for (int k = 0; k < 5; k++) begin
      drv_valid = tab_valid[k]; drv_ren = 1'b1; drv_wen = 1'b0; drv_addr = tab_addr[k];
      @(negedge clk);
      chk_eq($sformatf("l1 b2b stall c%0d", k), {31'd0, stall_s}, {31'd0, tab_stall[k]});
      chk_eq($sformatf("l1 b2b done c%0d", k), {31'd0, done_s}, {31'd0, tab_done[k]});
      chk_eq($sformatf("l1 b2b rdata c%0d", k), rdata_s, tab_rdata[k]);
      @(posedge clk); #1;
    end
    idle_bus();

    // LATENCY = 4: reset aborts an in-flight store
    sel = 4; #1;
    do_access("l4 sw8", 1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF, 4, 1'b0, 32'd0);
    do_access("l4 lw8", 1'b1, 1'b0, 32'h8, 32'd0, 4'h0, 4, 1'b1, 32'h12345678);
    drive_req(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk_eq("l4 busy stall", {31'd0, stall_s}, 32'd1);
    @(posedge clk); #1;
    rst4_n = 1'b0; #1;
    chk_eq("l4 rst stall", {31'd0, stall_s}, 32'd0);
    chk_eq("l4 rst done", {31'd0, done_s}, 32'd0);
    chk_eq("l4 rst err", {31'd0, err_s}, 32'd0);
    chk_eq("l4 rst rdata", rdata_s, 32'd0);
    repeat (4) @(posedge clk);
    #1 rst4_n = 1'b1;
    dbg_addr = 10'd2; #1;
    chk_eq("l4 word2 unchanged", dbg_s, 32'h12345678);
    @(posedge clk); #1;
    do_access("l4 lw8 post", 1'b1, 1'b0, 32'h8, 32'd0, 4'h0, 4, 1'b1, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
